// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the adder-sharing arbiter.
package adder_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Requester index width; never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adderPlus.sv
// Combinational WIDTH-bit adder with carry-out.
module adderPlus #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  assign {Carry, Sum} = {1'b0, inputA} + {1'b0, inputB};

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters, one-deep result register.
// Optional macro ADDER_ARB_SAT_EN: saturate the sum to all ones on carry-out.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  localparam int IDW    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_found;
  logic             accept;
  logic [WIDTH-1:0] a_sel, b_sel, add_sum, sum_nxt;
  logic             add_carry;

  // Search starts one past the last winner so every requester gets its turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign accept = gnt_found && ((state == IDLE) || rsp_ready);

  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adderPlus #(.WIDTH(WIDTH)) u_add (
    .inputA (a_sel),
    .inputB (b_sel),
    .Sum    (add_sum),
    .Carry  (add_carry)
  );

`ifdef ADDER_ARB_SAT_EN
  assign sum_nxt = add_carry ? {WIDTH{1'b1}} : add_sum;
`else
  assign sum_nxt = add_sum;
`endif

  // Result register doubles as the FSM; a new accept overwrites the held result as it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
      rr_ptr    <= IDW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_nxt;
            rsp_carry <= add_carry;
            rsp_id    <= gnt_idx;
            rr_ptr    <= gnt_idx;
          end
        end
        HOLD: begin
          if (accept) begin
            rsp_sum   <= sum_nxt;
            rsp_carry <= add_carry;
            rsp_id    <= gnt_idx;
            rr_ptr    <= gnt_idx;
          end else if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: vector table, directed corner sequences and a scoreboarded stress run.
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_sum;
  logic             rsp_carry;

  int n_checks = 0;
  int n_fail   = 0;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]   id;
    logic         carry;
    logic [W-1:0] sum;
  } rsp_t;

  function automatic rsp_t ref_add(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    r.id = 2'(id);
    r.carry = s[W];
    r.sum = s[W-1:0];
`ifdef ADDER_ARB_SAT_EN
    if (s[W]) r.sum = '1;
`endif
    return r;
  endfunction

  // Reference model + scoreboard, evaluated mid-cycle ahead of the next rising edge.
  rsp_t   sbq[$];
  int     mptr = N - 1;
  logic   mvalid = 1'b0;
  int     gidx;
  logic [N-1:0] er;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_sum", {rsp_id, rsp_carry, rsp_sum}, 0);
      mptr = N - 1;
      mvalid = 1'b0;
      sbq.delete();
    end else begin
      check("rsp_valid", rsp_valid, mvalid);
      if (mvalid && sbq.size() > 0) begin
        check("rsp_id", rsp_id, sbq[0].id);
        check("rsp_sum", rsp_sum, sbq[0].sum);
        check("rsp_carry", rsp_carry, sbq[0].carry);
      end
      gidx = -1;
      er = '0;
      if (!mvalid || rsp_ready)
        for (int k = 1; k <= N; k++)
          if (gidx < 0 && req_valid[(mptr + k) % N]) gidx = (mptr + k) % N;
      if (gidx >= 0) er[gidx] = 1'b1;
      check("req_ready", req_ready, er);
      if (mvalid && rsp_ready && sbq.size() > 0) void'(sbq.pop_front());
      if (gidx >= 0) begin
        sbq.push_back(ref_add(gidx, req_a[gidx*W +: W], req_b[gidx*W +: W]));
        mptr = gidx;
        mvalid = 1'b1;
      end else if (rsp_ready) begin
        mvalid = 1'b0;
      end
    end
  end

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  vec_t vt[6];
  logic [W-1:0] hold_sum;
  logic [1:0]   hold_id;

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] sat_ones;
    logic [W-1:0] sat_zero;
`ifdef ADDER_ARB_SAT_EN
    sat_ones = 32'hFFFF_FFFF;
    sat_zero = 32'hFFFF_FFFF;
`else
    sat_ones = 32'hFFFF_FFFF;
    sat_zero = 32'h0000_0000;
`endif
    vt[0] = '{2, 32'd5,          32'd7,          32'd12,         1'b0};
    vt[1] = '{0, 32'hFFFF_FFFF,  32'h0000_0001,  sat_zero,       1'b1};
    vt[2] = '{1, 32'h0,          32'h0,          32'h0,          1'b0};
    vt[3] = '{3, 32'h8000_0000,  32'h8000_0000,  sat_zero,       1'b1};
    vt[4] = '{2, 32'hDEAD_BEEF,  32'h1234_5678,  32'hF0E2_1567,  1'b0};
    vt[5] = '{1, 32'h7FFF_FFFF,  32'h0000_0001,  32'h8000_0000,  1'b0};

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single-requester vectors: same-cycle grant, result one cycle later.
    foreach (vt[v]) begin
      @(posedge clk); #2;
      req_valid = '0;
      req_valid[vt[v].id] = 1'b1;
      req_a[vt[v].id*W +: W] = vt[v].a;
      req_b[vt[v].id*W +: W] = vt[v].b;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("vec_ready", req_ready, 4'b0001 << vt[v].id);
      @(posedge clk); #2;
      req_valid = '0;
      @(negedge clk);
      check("vec_valid", rsp_valid, 1);
      check("vec_id", rsp_id, vt[v].id);
      check("vec_sum", rsp_sum, vt[v].sum);
      check("vec_carry", rsp_carry, vt[v].carry);
    end
    check("sat_ones_ref", sat_ones, vt[1].sum | 32'hFFFF_FFFF);

    // All requesters busy: strict rotation starting at 0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom;
      req_b[i*W +: W] = $urandom;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_grant", req_ready, 4'b0001 << (i % N));
    end

    // Back-pressure: no grants and a frozen result while the consumer stalls.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    @(negedge clk);
    hold_sum = rsp_sum;
    hold_id = rsp_id;
    check("bp_id", hold_id, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", req_ready, 0);
      check("bp_sum_stable", rsp_sum, hold_sum);
      check("bp_id_stable", rsp_id, hold_id);
      for (int j = 0; j < N; j++) req_a[j*W +: W] = $urandom;
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    #1 check("bp_release_grant", req_ready, 4'b0010);

    // Reset while holding a stalled result.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1 check("rst_kills_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0001);

    // Random stress against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < N; j++) begin
        req_a[j*W +: W] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_b[j*W +: W] = $urandom;
      end
    end
    @(posedge clk); #2;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_valid", rsp_valid, 0);
    check("drain_queue", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
